// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: arbitrates fetch and load/store requests onto a single-port word RAM bus.
// Define ARB_RR_EN for round-robin arbitration; otherwise load/store has fixed priority.
module mem_bus_ctrl #(
  parameter int MEM_WORDS  = 128,
  parameter int WORD_SHIFT = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ack,
  output logic [31:0] dm_rdata,
  output logic        acc_err,
  output logic        CS,
  output logic        WE,
  output logic [31:0] ADDR,
  inout  wire  [31:0] Mem_Bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_n;
  logic gnt_dm, we_q, err_q, sel_dm, bad, start;
  logic [31:0] wdata_q, wa;
`ifdef ARB_RR_EN
  logic last_dm;
  assign sel_dm = dm_req & (~if_req | ~last_dm);
`else
  assign sel_dm = dm_req;
`endif
  assign start = (state == IDLE) & (if_req | dm_req);
  assign wa = (sel_dm ? dm_addr : if_addr) >> WORD_SHIFT;
  assign bad = wa >= 32'(MEM_WORDS);
  assign CS = state == ACCESS;
  assign WE = CS & we_q;
  assign Mem_Bus = WE ? wdata_q : 'z;
  assign if_ack = (state == RESP) & ~gnt_dm;
  assign dm_ack = (state == RESP) & gnt_dm;
  assign acc_err = (state == RESP) & err_q;
  always_comb begin
    state_n = IDLE;
    state_n = start ? (bad ? RESP : ACCESS) : (state == ACCESS) ? RESP : IDLE;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      ADDR     <= '0;
      gnt_dm   <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      if_rdata <= '0;
      dm_rdata <= '0;
`ifdef ARB_RR_EN
      last_dm  <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (start) begin
        gnt_dm  <= sel_dm;
        we_q    <= sel_dm & dm_we;
        err_q   <= bad;
        wdata_q <= dm_wdata;
        if (!bad) ADDR <= wa;
`ifdef ARB_RR_EN
        last_dm <= sel_dm;
`endif
      end
      if (state == ACCESS && !we_q) begin
        if (gnt_dm) dm_rdata <= Mem_Bus;
        else if_rdata <= Mem_Bus;
      end
    end
  end
endmodule
